// File: rtl/mux64_arb_pkg.sv
// Shared constants, state encoding and select decode for the 64-way
// round-robin arbiter.
package mux64_arb_pkg;

  localparam int NREQ  = 64;
  localparam int SEL_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/mux64_rr_pick.sv
// Rotate-priority encoder: scans upward from ptr+1 and wraps, so ptr
// itself is the last candidate considered.
module mux64_rr_pick
  import mux64_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // First set request at or after ptr+1, modulo NREQ.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 1; i <= NREQ; i++) begin
      cand  = ptr + SEL_W'(i);
      idx   = (!found && req[cand]) ? cand : idx;
      found = found | req[cand];
    end
  end

endmodule

// File: rtl/mux64_rr_arb.sv
// 64:1 round-robin arbiter with release-on-done / drop-of-request and a
// bounded hold time that forces rotation after MAX_HOLD cycles.
module mux64_rr_arb
  import mux64_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] select,
  output logic             grant_valid,
  output logic [NREQ-1:0]  grant,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic             grant_valid_q, grant_valid_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             timeout_q, timeout_d;

  logic             found;
  logic [SEL_W-1:0] win_idx;
  logic             release_ev;
  logic             forced_ev;

  // ptr always equals the holder while granted, so one picker serves both
  // the idle search and the hand-off search (holder ends up lowest priority).
  mux64_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win_idx)
  );

  assign release_ev = done | ~req[select_q];
  assign forced_ev  = ~release_ev & (hold_cnt_q == HOLD_LIM);

  // Next-state, pointer, hold counter and output decode.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    select_d      = select_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d       = GRANT;
          ptr_d         = win_idx;
          select_d      = win_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = 8'd0;
        end else begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_ev || forced_ev) begin
          timeout_d = forced_ev;
          if (en && found) begin
            state_d       = GRANT;
            ptr_d         = win_idx;
            select_d      = win_idx;
            grant_valid_d = 1'b1;
            hold_cnt_d    = 8'd0;
          end else begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            hold_cnt_d    = 8'd0;
          end
        end else if (hold_cnt_q != HOLD_LIM) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        hold_cnt_d    = 8'd0;
      end
    endcase

    grant_d = sel_onehot(select_d) & {NREQ{grant_valid_d}};
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= 6'd63;
      hold_cnt_q    <= 8'd0;
      select_q      <= 6'd0;
      grant_valid_q <= 1'b0;
      grant_q       <= 64'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      select_q      <= select_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      timeout_q     <= timeout_d;
    end
  end

  assign select      = select_q;
  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mux64_rr_arb.sv
// Directed and random bench for mux64_rr_arb (MAX_HOLD=4) against an
// integer-based round-robin reference model.
module tb_mux64_rr_arb;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [63:0] req = 64'd0;
  logic        done = 1'b0;
  logic [5:0]  select;
  logic        grant_valid;
  logic [63:0] grant;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  // reference model: holder index or -1 when nobody is granted
  int m_holder, m_sel, m_ptr, m_cnt;
  bit m_to;

  mux64_rr_arb #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .done        (done),
    .select      (select),
    .grant_valid (grant_valid),
    .grant       (grant),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [63:0] r, input int start);
    for (int k = 0; k < 64; k++) begin
      if (r[(start + k) % 64]) return (start + k) % 64;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1; m_sel = 0; m_ptr = 63; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic model_clock();
    int  w;
    bit  rel, frc;
    if (m_holder < 0) begin
      m_to = 1'b0;
      w = en ? pick(req, m_ptr + 1) : -1;
      if (w >= 0) begin m_holder = w; m_sel = w; m_ptr = w; m_cnt = 0; end
    end else begin
      rel = done || !req[m_holder];
      frc = !rel && (m_cnt == MH - 1);
      if (rel || frc) begin
        m_to = frc;
        w = en ? pick(req, m_holder + 1) : -1;
        if (w >= 0) begin m_holder = w; m_sel = w; m_ptr = w; end
        else m_holder = -1;
        m_cnt = 0;
      end else begin
        m_to  = 1'b0;
        m_cnt = (m_cnt + 1 > MH - 1) ? MH - 1 : m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [63:0] eg;
    eg = (m_holder >= 0) ? (64'd1 << m_holder) : 64'd0;
    chk({tag, ".select"}, {58'd0, select}, 64'(m_sel));
    chk({tag, ".valid"},  {63'd0, grant_valid}, {63'd0, (m_holder >= 0)});
    chk({tag, ".grant"},  grant, eg);
    chk({tag, ".timeout"}, {63'd0, timeout}, {63'd0, m_to});
  endtask

  task automatic step(input string tag, input logic e, input logic [63:0] r, input logic d);
    en = e; req = r; done = d;
    @(posedge clk);
    model_clock();
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    en = 1'b0; req = 64'd0; done = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_model("reset");
  endtask

  initial begin
    logic [63:0] r;
    model_reset();

    // single request: one-cycle grant latency
    do_reset();
    step("r031", 1'b1, 64'd1 << 5, 1'b0);
    chk("r031.sel5", {58'd0, select}, 64'd5);

    // round robin 3,10,40,3 back-to-back on done
    do_reset();
    r = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 40);
    step("r032a", 1'b1, r, 1'b0);
    chk("r032.sel3", {58'd0, select}, 64'd3);
    step("r032b", 1'b1, r, 1'b1);
    chk("r032.sel10", {58'd0, select}, 64'd10);
    step("r032c", 1'b1, r, 1'b1);
    chk("r032.sel40", {58'd0, select}, 64'd40);
    step("r032d", 1'b1, r, 1'b1);
    chk("r032.sel3b", {58'd0, select}, 64'd3);
    chk("r032.nogap", {63'd0, grant_valid}, 64'd1);

    // wrap from 63 to 0
    do_reset();
    step("r033a", 1'b1, 64'd1 << 63, 1'b0);
    step("r033b", 1'b1, (64'd1 << 63) | 64'd1, 1'b1);
    chk("r033.wrap", {58'd0, select}, 64'd0);

    // forced release after MAX_HOLD cycles
    do_reset();
    r = (64'd1 << 7) | (64'd1 << 9);
    for (int i = 0; i < 4; i++) step("r034hold", 1'b1, r, 1'b0);
    chk("r034.still7", {58'd0, select}, 64'd7);
    step("r034to", 1'b1, r, 1'b0);
    chk("r034.to", {63'd0, timeout}, 64'd1);
    chk("r034.sel9", {58'd0, select}, 64'd9);

    // lone requester: periodic timeout, re-granted
    do_reset();
    for (int i = 0; i < 13; i++) step("r035", 1'b1, 64'd1 << 2, 1'b0);

    // release coincident with hold limit is a normal release
    do_reset();
    r = (64'd1 << 7) | (64'd1 << 9);
    for (int i = 0; i < 4; i++) step("r022hold", 1'b1, r, 1'b0);
    step("r022rel", 1'b1, r, 1'b1);
    chk("r022.noto", {63'd0, timeout}, 64'd0);

    // en=0 holds grant (timeout still runs), then done goes idle
    do_reset();
    step("r036a", 1'b1, 64'd1 << 12 | 64'd1 << 20, 1'b0);
    step("r036b", 1'b0, 64'd1 << 12 | 64'd1 << 20, 1'b0);
    step("r036c", 1'b0, 64'd1 << 12 | 64'd1 << 20, 1'b1);
    chk("r036.idle", {63'd0, grant_valid}, 64'd0);
    step("r036d", 1'b0, 64'd1 << 12, 1'b1);
    step("r036e", 1'b1, 64'd1 << 12, 1'b1);
    for (int i = 0; i < 5; i++) step("r024", 1'b0, 64'd1 << 12, 1'b0);

    // asynchronous reset mid-grant
    step("r036f", 1'b1, 64'd1 << 30, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    chk_model("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("r027", 1'b1, (64'd1 << 30) | (64'd1 << 63), 1'b0);
    chk("r027.first0", {58'd0, select}, 64'd30);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r = r & {$urandom, $urandom} & {$urandom, $urandom};
      if (m_holder >= 0 && $urandom_range(0, 3) != 0) r[m_holder] = 1'b1;
      if ($urandom_range(0, 9) == 0) r = 64'd0;
      step("rand", ($urandom_range(0, 7) != 0), r, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux64_rr_arb.md
MUX64_RR_ARB -- requirements
Module: mux64_rr_arb

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum cycles one grant is held before forced release, legal range 2..255.
REQ-002 Clock is clk, reset is rst. There is one clock. Reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 en  input  1  arbitration enable; 0 blocks new grants, current grant unaffected.
REQ-006 req  input  64  request lines, bit i = requester i; level-sensitive.
REQ-007 done  input  1  release strobe from current grant holder; sampled only while grant_valid=1.
REQ-008 select  output  6  registered index of granted requester; drives the 64:1 mux select.
REQ-009 grant_valid  output  1  registered; 1 while select names an active grant.
REQ-010 grant  output  64  registered one-hot of select, all-zero when grant_valid=0.
REQ-011 timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have two states: IDLE (no grant) and GRANT (grant held).
REQ-013 The round-robin search SHALL start at index (ptr+1) mod 64 and wrap ascending; the first set req bit is the winner.
REQ-014 IDLE→GRANT SHALL occur at the edge where en=1 and req≠0; select, grant and grant_valid update on that edge, so latency from req sampled to grant visible is 1 cycle.
REQ-015 On each new grant, ptr SHALL be loaded with the winner index.
REQ-016 A release event SHALL be done=1, or req[select]=0, sampled in GRANT.
REQ-017 On release with en=1 and other requests pending, the next winner SHALL be granted at the same edge with no idle cycle; the released index has lowest priority.
REQ-018 On release with no eligible request or en=0: →IDLE; grant_valid=0, grant=0, select holds its last value.
REQ-019 If the releasing requester still asserts req and is the only requester, it SHALL be re-granted (wrap-around).
REQ-020 hold_cnt SHALL clear on every new grant and increment each cycle in GRANT, saturating at MAX_HOLD-1.
REQ-021 When hold_cnt=MAX_HOLD-1 and no release is present, a forced release SHALL occur: timeout=1 for one cycle, and next grant per REQ-017/018/019.
REQ-022 A release coincident with the hold limit SHALL be treated as a normal release; timeout stays 0.
REQ-023 done in IDLE SHALL be ignored; done in GRANT is not required to be a single-cycle pulse, and each cycle it is high counts as one release.
REQ-024 en=0 in GRANT SHALL NOT terminate the current grant; the timeout still applies.
REQ-025 grant SHALL always equal one-hot(select) AND grant_valid; at most one bit is set.

Reset
REQ-026 When rst is asserted (any time, including mid-grant): state=IDLE, select=0, grant_valid=0, grant=0, timeout=0, hold_cnt=0, ptr=63 (first search starts at 0).
REQ-027 After reset deassertion, the first arbitration SHALL occur at the first rising edge with rst=0.

Structure
REQ-028 Package mux64_arb_pkg SHALL hold NREQ=64, SEL_W=6 and the state enum {IDLE, GRANT}.
REQ-029 Sub-module mux64_rr_pick SHALL be a combinational rotate-priority encoder with inputs req[63:0] and ptr[5:0], and outputs found and idx[5:0].
REQ-030 The top level SHALL contain the FSM, ptr, hold_cnt and output registers only.

Verification
REQ-031 Reset then req=bit5 → 1 cycle later select=5, grant_valid=1, grant=1<<5.
REQ-032 req={3,10,40} held, done pulsed each grant → grants go 3,10,40,3 in order, back-to-back with no grant_valid gap.
REQ-033 req=bit63|bit0, grant at 63, done → next select=0 (wrap).
REQ-034 MAX_HOLD=4, req=bit7|bit9 held, no done → grant 7 for 4 cycles, timeout pulse, then select=9.
REQ-035 Only req bit 2 held, no done → timeout every 4 cycles, select stays 2, grant_valid never drops.
REQ-036 en=0 mid-grant then done → IDLE; rst asserted mid-grant → outputs zero asynchronously and ptr=63.
